s_burst_tx: RTL and testbench
=============================

S_BURST_TX -- requirements
Module: s_burst_tx

Interface
REQ-001 Parameter SIZECOUNT, default 12, SHALL set the width of the burst length and remaining-word count.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the token data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous reset, active-low.
REQ-005 start  input  1  SHALL request a burst; sampled only in IDLE.
REQ-006 len  input  SIZECOUNT  SHALL give the word count of the burst; sampled with start.
REQ-007 abort  input  1  SHALL be a synchronous burst cancel, valid in any state.
REQ-008 src_data  input  DATA_WIDTH  SHALL be the first-word-fall-through source FIFO head.
REQ-009 src_empty  input  1  SHALL mark the source FIFO empty.
REQ-010 src_rd  output  1  SHALL pop one source word in the same cycle.
REQ-011 dst_data  output  DATA_WIDTH  SHALL be the registered token toward the receiver.
REQ-012 dst_valid  output  1  SHALL qualify dst_data.
REQ-013 dst_ready  input  1  SHALL be the receiver accept; a transfer occurs when dst_valid and dst_ready are both 1.
REQ-014 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-015 done  output  1  SHALL pulse for one cycle at burst completion.
REQ-016 remaining  output  SIZECOUNT  SHALL show words still to be read from the source.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 IDLE with start=1 and len!=0: load remaining<=len and go to RUN next cycle.
REQ-019 IDLE with start=1 and len==0: stay IDLE and pulse done the next cycle; no src_rd.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 src_rd SHALL be combinational: RUN and remaining!=0 and !src_empty and (!dst_valid or dst_ready) and !abort.
REQ-022 On src_rd: dst_data<=src_data, dst_valid<=1, remaining<=remaining-1 at the same edge; latency is 1 cycle from pop to dst_valid.
REQ-023 A transfer with no src_rd in the same cycle SHALL clear dst_valid; dst_data SHALL hold while dst_valid=1 and dst_ready=0.
REQ-024 Back-to-back throughput SHALL be 1 word/cycle while the source is non-empty and dst_ready=1.
REQ-025 RUN with remaining==0 SHALL go to DRAIN.
REQ-026 DRAIN SHALL go to IDLE and pulse done in the cycle after the last word transfers (dst_valid=0 next).
REQ-027 If the last pop and its transfer complete so that dst_valid=0 on entering DRAIN, done SHALL pulse on the next cycle.
REQ-028 remaining SHALL never wrap below 0; no pop occurs when remaining==0.
REQ-029 abort=1 in any state: next cycle state=IDLE, dst_valid=0, remaining=0, no done pulse; abort SHALL take priority over start and handshake.
REQ-030 src_empty rising mid-burst SHALL only stall popping; state and remaining hold.

Reset
REQ-031 rst low SHALL force state=IDLE, dst_valid=0, dst_data=0, remaining=0, done=0, busy=0 immediately, regardless of clk.
REQ-032 Reset asserted mid-burst SHALL discard the burst with no done pulse; operation resumes from IDLE after release.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, RUN=1, DRAIN=2) and the default SIZECOUNT/DATA_WIDTH constants.
REQ-034 The remaining counter SHALL be a sub-module s_dcnt: loadable down-counter with load, dec and clear inputs and the same async active-low reset.

Verification
REQ-035 len=4, source holds 4 words A..D, dst_ready=1 -> src_rd high 4 consecutive cycles, A..D on dst_data on 4 consecutive cycles, done 1 cycle after D transfers.
REQ-036 len=3, dst_ready low for 2 cycles after the first word -> dst_data holds the first word, no extra pop, 3 words total, remaining 3->2->1->0.
REQ-037 start with len=0 -> done pulses the next cycle, busy stays 0, src_rd never asserted.
REQ-038 len=5, src_empty=1 after 2 words for 3 cycles -> remaining holds at 3, burst completes after refill with exactly 5 words.
REQ-039 abort after 2 of 6 words -> next cycle IDLE, dst_valid=0, remaining=0, no done; a following start with len=2 runs normally.
REQ-040 rst low mid-burst (len=8, 3 sent) -> outputs reach reset values asynchronously; no done; a new burst after release is correct.

Source files
------------

// File: rtl/s_burst_tx_pkg.sv
// Shared definitions for the burst transmitter: FSM encoding and default widths.
package s_burst_tx_pkg;

   localparam int unsigned SizeCountDefault = 12;
   localparam int unsigned DataWidthDefault = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

endpackage

// File: rtl/s_dcnt.sv
// Loadable down-counter with clear; saturates at zero.
module s_dcnt #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/s_burst_tx.sv
// Moves a fixed-length burst from a FWFT source FIFO to a valid/ready sink, one word per cycle.
module s_burst_tx
   import s_burst_tx_pkg::*;
#(
   parameter int unsigned SIZECOUNT  = SizeCountDefault,
   parameter int unsigned DATA_WIDTH = DataWidthDefault
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SIZECOUNT-1:0]  len,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  src_empty,
   output logic                  src_rd,
   output logic [DATA_WIDTH-1:0] dst_data,
   output logic                  dst_valid,
   input  logic                  dst_ready,
   output logic                  busy,
   output logic                  done,
   output logic [SIZECOUNT-1:0]  remaining
);

   state_e                state_q, state_d;
   logic                  dst_valid_q, dst_valid_d;
   logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
   logic                  done_q, done_d;
   logic                  cnt_load, cnt_clear;
   logic                  rem_zero;
   logic                  out_free;

   assign rem_zero = (remaining == '0);
   // Output register can take a new word when empty or being drained this cycle.
   assign out_free = !dst_valid_q || dst_ready;

   s_dcnt #(
      .WIDTH (SIZECOUNT)
   ) u_dcnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .dec      (src_rd),
      .load_val (len),
      .count    (remaining)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start && (len != '0)) state_d = StRun;
            StRun:   if (rem_zero) state_d = StDrain;
            StDrain: if (out_free) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      src_rd    = (state_q == StRun) && !rem_zero && !src_empty && out_free && !abort;
      cnt_clear = abort;
      cnt_load  = !abort && (state_q == StIdle) && start && (len != '0);
      done_d    = !abort && (((state_q == StIdle) && start && (len == '0)) ||
                             ((state_q == StDrain) && out_free));
   end

   always_comb begin
      dst_valid_d = dst_valid_q;
      dst_data_d  = dst_data_q;
      if (abort) begin
         dst_valid_d = 1'b0;
      end else if (src_rd) begin
         dst_valid_d = 1'b1;
         dst_data_d  = src_data;
      end else if (dst_valid_q && dst_ready) begin
         dst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         dst_valid_q <= dst_valid_d;
         dst_data_q  <= dst_data_d;
         done_q      <= done_d;
      end
   end

   assign dst_valid = dst_valid_q;
   assign dst_data  = dst_data_q;
   assign done      = done_q;

endmodule

// File: tb/tb_s_burst_tx.sv
// Bench for s_burst_tx: directed bursts with literal pins plus randomized traffic vs a model.
module tb_s_burst_tx;

   localparam int SC = 12;
   localparam int DW = 32;
   localparam int PIdle  = 0;
   localparam int PRun   = 1;
   localparam int PDrain = 2;

   logic          clk = 1'b0;
   logic          rst, start, abort, src_empty, dst_ready;
   logic [SC-1:0] len;
   logic [DW-1:0] src_data;
   logic          src_rd, dst_valid, busy, done;
   logic [DW-1:0] dst_data;
   logic [SC-1:0] remaining;

   always #5 clk = ~clk;

   s_burst_tx #(
      .SIZECOUNT  (SC),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .src_data  (src_data),
      .src_empty (src_empty),
      .src_rd    (src_rd),
      .dst_data  (dst_data),
      .dst_valid (dst_valid),
      .dst_ready (dst_ready),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] src_q[$];
   bit            stall;
   bit            chk_en;

   // Reference model state: what the outputs must show after the latest edge.
   int            m_phase;
   int            m_rem;
   bit            m_dv;
   logic [DW-1:0] m_data;
   bit            m_done;
   int            m_len;
   int            xfer_cnt;

   logic [DW-1:0] wa[4] = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
   logic [DW-1:0] v[8];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit exp_rd();
      return (m_phase == PRun) && (m_rem != 0) && !src_empty && (!m_dv || dst_ready) && !abort;
   endfunction

   task automatic drive_src();
      src_empty = stall || (src_q.size() == 0);
      if (src_q.size() != 0) src_data = src_q[0];
      else src_data = '0;
   endtask

   task automatic model_reset();
      m_phase = PIdle;
      m_rem   = 0;
      m_dv    = 1'b0;
      m_data  = '0;
      m_done  = 1'b0;
   endtask

   task automatic model_update(output bit pop);
      bit xfer, rem_was_zero, dv_old;
      pop          = exp_rd();
      xfer         = m_dv && dst_ready;
      rem_was_zero = (m_rem == 0);
      dv_old       = m_dv;
      if (abort) begin
         m_phase = PIdle;
         m_dv    = 1'b0;
         m_rem   = 0;
         m_done  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (pop) begin
            m_data = src_data;
            m_dv   = 1'b1;
            m_rem  = m_rem - 1;
         end else if (xfer) begin
            m_dv = 1'b0;
         end
         case (m_phase)
            PIdle: if (start) begin
               m_len    = int'(len);
               xfer_cnt = 0;
               if (len == '0) m_done = 1'b1;
               else begin
                  m_rem   = int'(len);
                  m_phase = PRun;
               end
            end
            PRun:   if (rem_was_zero) m_phase = PDrain;
            PDrain: if (!dv_old || dst_ready) begin
               m_phase = PIdle;
               m_done  = 1'b1;
            end
            default: m_phase = PIdle;
         endcase
      end
   endtask

   task automatic compare();
      chk("busy", busy, m_phase != PIdle);
      chk("done", done, m_done);
      chk("dst_valid", dst_valid, m_dv);
      if (m_dv) chk("dst_data", dst_data, m_data);
      chk("remaining", remaining, m_rem);
      chk("src_rd", src_rd, exp_rd());
      if (dst_valid && dst_ready) xfer_cnt++;
      if (m_done) chk("burst_words", xfer_cnt, m_len);
   endtask

   task automatic step();
      bit pop, ab;
      drive_src();
      @(negedge clk);
      if (chk_en) compare();
      @(posedge clk);
      ab  = abort;
      pop = 1'b0;
      if (rst) model_update(pop);
      else model_reset();
      #1;
      if (pop) void'(src_q.pop_front());
      if (ab) src_q.delete();
      drive_src();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(m_phase == PIdle && !m_done) && n < 300) begin
         step();
         n++;
      end
      chk("wait_idle_bound", n < 300, 1);
   endtask

   task automatic begin_burst(input int n);
      for (int i = 0; i < n; i++) begin
         v[i] = $urandom;
         src_q.push_back(v[i]);
      end
      len   = SC'(n);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0; stall = 1'b0; dst_ready = 1'b1;
      chk_en = 1'b0; m_len = 0; xfer_cnt = 0;
      model_reset();
      drive_src();
      #12;
      chk("rst_dst_valid", dst_valid, 0);
      chk("rst_dst_data", dst_data, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_src_rd", src_rd, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk_en = 1'b1;

      // Four words back to back with the sink always ready.
      for (int i = 0; i < 4; i++) src_q.push_back(wa[i]);
      len = SC'(4); start = 1'b1;
      step();
      start = 1'b0;
      chk("b4_rem_load", remaining, 4);
      chk("b4_busy", busy, 1);
      chk("b4_first_rd", src_rd, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("b4_data", dst_data, wa[k]);
         chk("b4_valid", dst_valid, 1);
         chk("b4_rem", remaining, 3 - k);
         chk("b4_rd", src_rd, k < 3);
      end
      step();
      chk("b4_drain_valid", dst_valid, 0);
      chk("b4_drain_done", done, 0);
      chk("b4_drain_busy", busy, 1);
      step();
      chk("b4_done", done, 1);
      chk("b4_idle", busy, 0);
      step();
      chk("b4_done_pulse", done, 0);

      // Zero-length burst.
      len = '0; start = 1'b1;
      step();
      start = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_rd", src_rd, 0);
      step();
      chk("z_done_pulse", done, 0);

      // Sink back-pressure after the first word.
      begin_burst(3);
      chk("bp_rem0", remaining, 3);
      step();
      chk("bp_data0", dst_data, v[0]);
      chk("bp_rem1", remaining, 2);
      dst_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("bp_hold_data", dst_data, v[0]);
         chk("bp_hold_rem", remaining, 2);
         chk("bp_no_pop", src_rd, 0);
      end
      dst_ready = 1'b1;
      wait_idle();

      // Source runs dry mid-burst.
      begin_burst(5);
      step();
      step();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("st_rem_hold", remaining, 3);
      end
      stall = 1'b0;
      wait_idle();

      // Abort after two words, then a normal burst.
      begin_burst(6);
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_valid", dst_valid, 0);
      chk("ab_rem", remaining, 0);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      step();
      chk("ab_no_done", done, 0);
      begin_burst(2);
      wait_idle();

      // Reset in the middle of a burst.
      begin_burst(8);
      for (int k = 0; k < 3; k++) step();
      #2;
      rst = 1'b0;
      #1;
      chk("mr_valid", dst_valid, 0);
      chk("mr_data", dst_data, 0);
      chk("mr_rem", remaining, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk_en = 1'b0;
      model_reset();
      src_q.delete();
      step();
      step();
      rst = 1'b1;
      chk_en = 1'b1;
      begin_burst(3);
      wait_idle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start     = 1'b0;
         len       = SC'($urandom_range(0, 15));
         abort     = ($urandom_range(0, 59) == 0);
         dst_ready = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 4) == 0);
         if (m_phase == PIdle) begin
            if ($urandom_range(0, 2) == 0) begin
               start = 1'b1;
               len   = SC'($urandom_range(0, 9));
               for (int n = 0; n < int'(len); n++) src_q.push_back($urandom);
            end
         end else begin
            start = ($urandom_range(0, 7) == 0);
         end
         step();
      end
      start = 1'b0; abort = 1'b0; stall = 1'b0; dst_ready = 1'b1;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
